drift_session_sequencer: RTL and testbench
==========================================

// Module: drift_session_sequencer
// PURPOSE
//  Runs one drift-scoring session around the range/speed tracker.
//  Requests range samples from the sensor front-end at a fixed period and forwards them to the tracker.
//  Holds the tracker in reset until the first valid sample is available.
//  Ends the session after a set number of samples and latches the tracker's min-range/max-speed result.
// PARAMETERS
//  SAMPLE_DIV       50000  clock cycles per sample period (>=4)
//  SESSION_SAMPLES  1000   accepted samples per session, first (priming) sample excluded (>=1)
//  RANGE_W          10     range width
//  SPEED_W          8      speed width
// PORTS
//  i_clk            in   1        clock
//  i_rst            in   1        reset: synchronous, active-high
//  i_start          in   1        session start pulse; acted on in IDLE and DONE
//  i_abort          in   1        abort; acted on in CLEAR, RUN and DRAIN
//  i_range_valid    in   1        sensor sample valid (1-cycle pulse)
//  i_range          in   RANGE_W  sensor sample
//  i_min_range      in   RANGE_W  tracker min-range output
//  i_max_speed      in   SPEED_W  tracker max-speed output
//  o_sample_req     out  1        sample request level, held until i_range_valid
//  o_range          out  RANGE_W  registered sample fed to tracker
//  o_stat_rst       out  1        tracker reset
//  o_busy           out  1        high in CLEAR/RUN/DRAIN
//  o_done           out  1        high in DONE
//  o_min_range_lat  out  RANGE_W  latched session min range
//  o_max_speed_lat  out  SPEED_W  latched session max speed
//  o_miss_cnt       out  8        missed sample periods this session, saturates at 255
//  o_state          out  3        IDLE=0 CLEAR=1 RUN=2 DRAIN=3 DONE=4
// BEHAVIOUR
//  Reset: state IDLE; all outputs and internal counters 0.
//  IDLE
//   - o_sample_req=0; o_stat_rst=0.
//   - i_start & !i_abort -> CLEAR; i_start & i_abort -> stay IDLE.
//   - Entering CLEAR clears o_miss_cnt, the sample counter and the period counter.
//  CLEAR
//   - o_sample_req=1.
//   - On i_range_valid: o_range<=i_range next edge, then -> RUN.
//   - No timeout in CLEAR; misses are not counted.
//  o_stat_rst
//   - Registered; high every cycle state==CLEAR, plus exactly 1 cycle after leaving CLEAR.
//   - The tracker therefore sees reset with the priming sample on o_range.
//  RUN
//   - Period counter runs 0..SAMPLE_DIV-1 and wraps; starts at 0 on RUN entry.
//   - At the wrap, o_sample_req is set to 1 on the next cycle.
//   - Valid while req=1: o_range<=i_range, req<=0, sample_cnt+1.
//   - i_range_valid while req=0: ignored, o_range unchanged.
//   - Wrap while req=1 and no valid that cycle: o_miss_cnt+1 (saturating); req stays 1.
//   - Wrap and valid in the same cycle: sample accepted, no miss counted, req re-raised next cycle.
//   - sample_cnt reaching SESSION_SAMPLES -> DRAIN on the next edge, req<=0.
//  DRAIN
//   - Exactly 2 cycles, so the tracker absorbs the last o_range.
//   - On the 2nd cycle: o_min_range_lat<=i_min_range, o_max_speed_lat<=i_max_speed.
//   - Then -> DONE.
//  DONE
//   - o_done=1; latched results and o_miss_cnt held.
//   - i_start -> CLEAR; latches keep the old values until the next DRAIN.
//  Abort
//   - i_abort in CLEAR, RUN or DRAIN -> IDLE next edge.
//   - req<=0, latches NOT updated, o_stat_rst follows the IDLE rule after the registered tail.
//  i_rst mid-session: immediate return to reset state; all latched results cleared.
//  Counter widths: $clog2(SAMPLE_DIV) and $clog2(SESSION_SAMPLES+1); no wrap past terminal.
// TESTING
//  T1
//   - Reset, i_start, valid range=300 at CLEAR+5.
//   - Expect o_stat_rst high 7 cycles, o_range=300, state RUN.
//  T2
//   - SAMPLE_DIV=8, SESSION_SAMPLES=3; sensor answers 2 cycles after each req with 300,250,200,180.
//   - Expect DONE.
//   - Expect latches equal the tracker values sampled at DRAIN cycle 2.
//   - Expect o_miss_cnt=0.
//  T3
//   - SAMPLE_DIV=8; withhold valid for 3 periods in RUN.
//   - Expect o_miss_cnt=3 and req held high throughout.
//   - Expect the next valid to be accepted.
//  T4
//   - Valid pulse while req=0 with value 5.
//   - Expect o_range unchanged and sample_cnt unchanged.
//   - Valid coincident with the wrap: expect accepted and no miss.
//  T5
//   - i_abort during RUN.
//   - Expect IDLE, req=0, latches retain the previous session values.
//   - i_start & i_abort together in IDLE: expect stays IDLE.
//  T6
//   - i_rst asserted in DRAIN: expect all outputs 0, state IDLE.
//   - Restart from DONE via i_start: expect o_miss_cnt cleared on CLEAR entry.

Source files
------------

// File: rtl/drift_session_sequencer_if.sv
// Bundles the sequencer's control, sensor and tracker signals. The sequencer takes
// the slave side; whatever drives start/abort, the sensor and the tracker sits on
// the master side.
interface drift_session_sequencer_if #(
  parameter int unsigned RANGE_W = 10,
  parameter int unsigned SPEED_W = 8
);
  logic               i_start;
  logic               i_abort;
  logic               i_range_valid;
  logic [RANGE_W-1:0] i_range;
  logic [RANGE_W-1:0] i_min_range;
  logic [SPEED_W-1:0] i_max_speed;
  logic               o_sample_req;
  logic [RANGE_W-1:0] o_range;
  logic               o_stat_rst;
  logic               o_busy;
  logic               o_done;
  logic [RANGE_W-1:0] o_min_range_lat;
  logic [SPEED_W-1:0] o_max_speed_lat;
  logic [7:0]         o_miss_cnt;
  logic [2:0]         o_state;

  modport slave (
    input  i_start, i_abort, i_range_valid, i_range, i_min_range, i_max_speed,
    output o_sample_req, o_range, o_stat_rst, o_busy, o_done,
           o_min_range_lat, o_max_speed_lat, o_miss_cnt, o_state
  );

  modport master (
    output i_start, i_abort, i_range_valid, i_range, i_min_range, i_max_speed,
    input  o_sample_req, o_range, o_stat_rst, o_busy, o_done,
           o_min_range_lat, o_max_speed_lat, o_miss_cnt, o_state
  );
endinterface

// File: rtl/drift_session_sequencer.sv
// Sequences one drift-scoring session: primes the tracker with a first sample while
// holding it in reset, then requests samples once per period, counts missed periods,
// and latches the tracker's min-range / max-speed after a short drain.
module drift_session_sequencer #(
  parameter int unsigned SAMPLE_DIV      = 50000,
  parameter int unsigned SESSION_SAMPLES = 1000,
  parameter int unsigned RANGE_W         = 10,
  parameter int unsigned SPEED_W         = 8
) (
  input logic                      i_clk,
  input logic                      i_rst,
  drift_session_sequencer_if.slave bus
);

  localparam int unsigned PerW = $clog2(SAMPLE_DIV);
  localparam int unsigned CntW = $clog2(SESSION_SAMPLES + 1);
  localparam logic [PerW-1:0] PerLast = PerW'(SAMPLE_DIV - 1);
  localparam logic [CntW-1:0] CntLast = CntW'(SESSION_SAMPLES);

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StClear = 3'd1,
    StRun   = 3'd2,
    StDrain = 3'd3,
    StDone  = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic               req_q, req_d;
  logic [RANGE_W-1:0] range_q, range_d;
  logic               stat_rst_q;
  logic [RANGE_W-1:0] min_lat_q, min_lat_d;
  logic [SPEED_W-1:0] spd_lat_q, spd_lat_d;
  logic [7:0]         miss_q, miss_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [PerW-1:0]    per_q, per_d;
  logic               drain_q, drain_d;
  logic               wrap;

  assign wrap = (per_q == PerLast);

  // State and datapath registers; the tracker reset covers CLEAR plus one tail cycle
  // so the tracker is reset while the priming sample sits on o_range.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= StIdle;
      req_q      <= 1'b0;
      range_q    <= '0;
      stat_rst_q <= 1'b0;
      min_lat_q  <= '0;
      spd_lat_q  <= '0;
      miss_q     <= '0;
      cnt_q      <= '0;
      per_q      <= '0;
      drain_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      range_q    <= range_d;
      stat_rst_q <= (state_d == StClear) || (state_q == StClear);
      min_lat_q  <= min_lat_d;
      spd_lat_q  <= spd_lat_d;
      miss_q     <= miss_d;
      cnt_q      <= cnt_d;
      per_q      <= per_d;
      drain_q    <= drain_d;
    end
  end

  // Next-state logic for the session FSM and its counters.
  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    range_d   = range_q;
    min_lat_d = min_lat_q;
    spd_lat_d = spd_lat_q;
    miss_d    = miss_q;
    cnt_d     = cnt_q;
    per_d     = per_q;
    drain_d   = 1'b0;

    case (state_q)
      StIdle, StDone: begin
        // Abort only blocks a start from IDLE; DONE restarts unconditionally.
        if (bus.i_start && (state_q == StDone || !bus.i_abort)) begin
          state_d = StClear;
          req_d   = 1'b1;
          miss_d  = '0;
          cnt_d   = '0;
          per_d   = '0;
        end
      end
      StClear: begin
        if (bus.i_abort) begin
          state_d = StIdle;
          req_d   = 1'b0;
        end else if (bus.i_range_valid) begin
          range_d = bus.i_range;
          req_d   = 1'b0;
          per_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        if (bus.i_abort) begin
          state_d = StIdle;
          req_d   = 1'b0;
        end else if (cnt_q == CntLast) begin
          state_d = StDrain;
          req_d   = 1'b0;
        end else begin
          per_d = wrap ? '0 : per_q + PerW'(1);
          if (req_q && bus.i_range_valid) begin
            range_d = bus.i_range;
            cnt_d   = cnt_q + CntW'(1);
            req_d   = wrap;  // a wrap in the same cycle immediately re-requests
          end else if (wrap) begin
            req_d = 1'b1;
            if (req_q && miss_q != 8'hFF) begin
              miss_d = miss_q + 8'd1;
            end
          end
        end
      end
      StDrain: begin
        if (bus.i_abort) begin
          state_d = StIdle;
          req_d   = 1'b0;
        end else if (drain_q) begin
          min_lat_d = bus.i_min_range;
          spd_lat_d = bus.i_max_speed;
          state_d   = StDone;
        end else begin
          drain_d = 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
        req_d   = 1'b0;
      end
    endcase
  end

  assign bus.o_sample_req    = req_q;
  assign bus.o_range         = range_q;
  assign bus.o_stat_rst      = stat_rst_q;
  assign bus.o_busy          = (state_q == StClear) || (state_q == StRun) || (state_q == StDrain);
  assign bus.o_done          = (state_q == StDone);
  assign bus.o_min_range_lat = min_lat_q;
  assign bus.o_max_speed_lat = spd_lat_q;
  assign bus.o_miss_cnt      = miss_q;
  assign bus.o_state         = state_q;

endmodule

// File: tb/tb_drift_session_sequencer.sv
// Bench for drift_session_sequencer: a small tracker model drives the min/max inputs,
// accepted samples are tracked in a scoreboard queue, and sessions exercise priming,
// misses, ignored and wrap-coincident samples, abort and mid-drain reset.
module tb_drift_session_sequencer;
  localparam int unsigned SampleDiv      = 8;
  localparam int unsigned SessionSamples = 3;
  localparam int unsigned RangeW         = 10;
  localparam int unsigned SpeedW         = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  drift_session_sequencer_if #(.RANGE_W(RangeW), .SPEED_W(SpeedW)) bus ();

  drift_session_sequencer #(
    .SAMPLE_DIV     (SampleDiv),
    .SESSION_SAMPLES(SessionSamples),
    .RANGE_W        (RangeW),
    .SPEED_W        (SpeedW)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus)
  );

  int n_cmp = 0;
  int n_err = 0;
  logic [RangeW-1:0] exp_q[$];
  logic [RangeW-1:0] last_range;

  // Tracker model: min of o_range and max step between consecutive cycles.
  logic [RangeW-1:0] trk_min, trk_prev, trk_diff;
  logic [SpeedW-1:0] trk_spd;
  always_comb begin
    trk_diff = (bus.o_range > trk_prev) ? bus.o_range - trk_prev : trk_prev - bus.o_range;
  end
  always @(posedge clk) begin
    if (bus.o_stat_rst) begin
      trk_min  <= bus.o_range;
      trk_prev <= bus.o_range;
      trk_spd  <= '0;
    end else begin
      if (bus.o_range < trk_min) trk_min <= bus.o_range;
      if (trk_diff > RangeW'(trk_spd)) trk_spd <= trk_diff[SpeedW-1:0];
      trk_prev <= bus.o_range;
    end
  end
  assign bus.i_min_range = trk_min;
  assign bus.i_max_speed = trk_spd;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  // Every change of o_range must be the next accepted sample in the queue.
  always @(negedge clk) begin
    if (rst) begin
      last_range <= '0;
    end else if (bus.o_range !== last_range) begin
      if (exp_q.size() == 0) check_eq("range_unexpected", bus.o_range, last_range);
      else check_eq("range", bus.o_range, exp_q.pop_front());
      last_range <= bus.o_range;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req(input int budget);
    int n = 0;
    while (!bus.o_sample_req && n < budget) begin
      tick();
      n++;
    end
    if (!bus.o_sample_req) check_eq("req_timeout", bus.o_sample_req, 1);
  endtask

  task automatic wait_state(input logic [2:0] st, input int budget);
    int n = 0;
    while (bus.o_state != st && n < budget) begin
      tick();
      n++;
    end
    check_eq("state_wait", bus.o_state, st);
  endtask

  // Sensor: answer a request after `delay` cycles with a 1-cycle valid pulse.
  task automatic serve(input logic [RangeW-1:0] v, input int delay);
    wait_req(100);
    repeat (delay) tick();
    bus.i_range       = v;
    bus.i_range_valid = 1'b1;
    exp_q.push_back(v);
    tick();
    bus.i_range_valid = 1'b0;
  endtask

  task automatic check_idle_zero(input string tag);
    check_eq({tag, "_req"}, bus.o_sample_req, 0);
    check_eq({tag, "_range"}, bus.o_range, 0);
    check_eq({tag, "_stat_rst"}, bus.o_stat_rst, 0);
    check_eq({tag, "_busy"}, bus.o_busy, 0);
    check_eq({tag, "_done"}, bus.o_done, 0);
    check_eq({tag, "_min_lat"}, bus.o_min_range_lat, 0);
    check_eq({tag, "_spd_lat"}, bus.o_max_speed_lat, 0);
    check_eq({tag, "_miss"}, bus.o_miss_cnt, 0);
    check_eq({tag, "_state"}, bus.o_state, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n_sr;
    int n_low;
    rst               = 1'b1;
    bus.i_start       = 1'b0;
    bus.i_abort       = 1'b0;
    bus.i_range_valid = 1'b0;
    bus.i_range       = '0;
    repeat (3) tick();
    check_idle_zero("reset");
    rst = 1'b0;
    tick();

    // Session A: priming sample 6 cycles into CLEAR, then three clean samples.
    bus.i_start = 1'b1;
    tick();
    bus.i_start = 1'b0;
    n_sr = bus.o_stat_rst ? 1 : 0;
    check_eq("clear_state", bus.o_state, 1);
    check_eq("clear_req", bus.o_sample_req, 1);
    check_eq("clear_busy", bus.o_busy, 1);
    repeat (5) begin
      tick();
      if (bus.o_stat_rst) n_sr++;
    end
    bus.i_range       = 10'd300;
    bus.i_range_valid = 1'b1;
    exp_q.push_back(10'd300);
    tick();
    bus.i_range_valid = 1'b0;
    if (bus.o_stat_rst) n_sr++;
    check_eq("prime_state", bus.o_state, 2);
    check_eq("prime_range", bus.o_range, 300);
    tick();
    if (bus.o_stat_rst) n_sr++;
    check_eq("stat_rst_cycles", n_sr, 7);
    serve(10'd250, 2);
    serve(10'd200, 2);
    serve(10'd180, 2);
    wait_state(3'd4, 50);
    check_eq("a_done", bus.o_done, 1);
    check_eq("a_busy", bus.o_busy, 0);
    check_eq("a_min_lat", bus.o_min_range_lat, 180);
    check_eq("a_spd_lat", bus.o_max_speed_lat, 50);
    check_eq("a_miss", bus.o_miss_cnt, 0);

    // Session B: restart from DONE, three missed periods, ignored and wrap-aligned valids.
    bus.i_start = 1'b1;
    tick();
    bus.i_start = 1'b0;
    check_eq("b_miss_cleared", bus.o_miss_cnt, 0);
    check_eq("b_min_lat_kept", bus.o_min_range_lat, 180);
    serve(10'd400, 0);
    wait_req(50);
    n_low = 0;
    repeat (3 * SampleDiv) begin
      tick();
      if (!bus.o_sample_req) n_low++;
    end
    check_eq("miss_req_low_cycles", n_low, 0);
    check_eq("miss_cnt3", bus.o_miss_cnt, 3);
    bus.i_range       = 10'd410;
    bus.i_range_valid = 1'b1;
    exp_q.push_back(10'd410);
    tick();
    bus.i_range       = 10'd5;
    tick();
    bus.i_range_valid = 1'b0;
    check_eq("ignored_valid_range", bus.o_range, 410);
    repeat (13) tick();
    check_eq("pre_wrap_req", bus.o_sample_req, 1);
    bus.i_range       = 10'd420;
    bus.i_range_valid = 1'b1;
    exp_q.push_back(10'd420);
    tick();
    bus.i_range_valid = 1'b0;
    check_eq("wrap_valid_no_miss", bus.o_miss_cnt, 3);
    check_eq("wrap_valid_req_reraised", bus.o_sample_req, 1);
    serve(10'd430, 1);
    wait_state(3'd4, 50);
    check_eq("b_min_lat", bus.o_min_range_lat, 400);
    check_eq("b_spd_lat", bus.o_max_speed_lat, 10);
    check_eq("b_miss", bus.o_miss_cnt, 3);

    // Session C: abort in RUN keeps previous latches.
    bus.i_start = 1'b1;
    tick();
    bus.i_start = 1'b0;
    check_eq("c_miss_cleared", bus.o_miss_cnt, 0);
    serve(10'd500, 0);
    repeat (4) tick();
    bus.i_abort = 1'b1;
    tick();
    bus.i_abort = 1'b0;
    check_eq("abort_state", bus.o_state, 0);
    check_eq("abort_req", bus.o_sample_req, 0);
    check_eq("abort_busy", bus.o_busy, 0);
    check_eq("abort_min_lat", bus.o_min_range_lat, 400);
    check_eq("abort_spd_lat", bus.o_max_speed_lat, 10);
    check_eq("abort_stat_rst", bus.o_stat_rst, 0);
    bus.i_start = 1'b1;
    bus.i_abort = 1'b1;
    tick();
    bus.i_start = 1'b0;
    bus.i_abort = 1'b0;
    check_eq("start_abort_state", bus.o_state, 0);
    check_eq("start_abort_req", bus.o_sample_req, 0);

    // Session D: reset during DRAIN clears everything.
    bus.i_start = 1'b1;
    tick();
    bus.i_start = 1'b0;
    serve(10'd600, 0);
    serve(10'd610, 0);
    serve(10'd620, 0);
    serve(10'd630, 0);
    wait_state(3'd3, 20);
    rst = 1'b1;
    tick();
    check_idle_zero("rst_drain");
    rst = 1'b0;
    tick();
    check_eq("sb_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
